// File: rtl/uart_frame_decoder_if.sv
// Byte-stream bundle around uart_frame_decoder: upstream byte handshake,
// downstream payload handshake and the error strobe.
interface uart_frame_decoder_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       err_valid;
  logic [1:0] err_code;

  // Environment side: feeds bytes in, accepts payload out.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, err_valid, err_code
  );

  // Decoder side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, err_valid, err_code
  );
endinterface

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: hunts for SYNC, reads a length byte, payload and an
// additive checksum, and replays the buffered payload downstream only once
// the checksum matches. Bad frames are dropped with a one-cycle error strobe.
module uart_frame_decoder #(
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 1400
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_frame_decoder_if.slave  bus
);

  localparam int unsigned PTR_W  = $clog2(MAX_LEN + 1);
  localparam int unsigned ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(TIMEOUT);
  // The error fires at the end of the TIMEOUT-th idle cycle, i.e. while the
  // counter still shows TIMEOUT-1, so a byte arriving in that cycle wins.
  localparam logic [IDLE_W-1:0] IDLE_LAST = (TIMEOUT > 0) ? IDLE_W'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    ST_HUNT, ST_LEN, ST_PAYLOAD, ST_CHK, ST_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BAD_LEN = 2'd1,
    ERR_BAD_CHK = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_t;

  state_t            state_q, state_d;
  logic [7:0]        len_q;
  logic [7:0]        sum_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [IDLE_W-1:0] idle_q;
  logic              err_valid_q;
  err_t              err_code_q;
  logic [7:0]        payload_mem [MAX_LEN];

  logic              accept;
  logic              pop;
  logic              len_ok;
  logic              in_frame;
  logic              next_in_frame;
  logic              timeout_hit;
  logic              err_fire;
  err_t              err_cause;
  logic [7:0]        last_idx;

  // Handshake decode and frame-level conditions.
  assign bus.in_ready  = (state_q != ST_DRAIN);
  assign accept        = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign len_ok        = (bus.in_data != 8'd0) && (bus.in_data <= MAX_LEN_B);
  assign in_frame      = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
  assign next_in_frame = (state_d == ST_LEN) || (state_d == ST_PAYLOAD) || (state_d == ST_CHK);
  assign timeout_hit   = (TIMEOUT > 0) && in_frame && !accept && (idle_q == IDLE_LAST);
  assign last_idx      = len_q - 8'd1;

  // Output stream: the buffer is read combinationally at rd_ptr, so data and
  // last stay put for as long as the consumer stalls.
  assign bus.out_valid = (state_q == ST_DRAIN);
  assign bus.out_data  = payload_mem[rd_ptr_q[ADDR_W-1:0]];
  assign bus.out_last  = (state_q == ST_DRAIN) && (8'(rd_ptr_q) == last_idx);
  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = err_code_q;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential logic uses <= so every flop samples pre-edge values.
    if (reset) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and error cause selection.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal; no latches.
    state_d   = state_q;
    err_fire  = 1'b0;
    err_cause = ERR_NONE;
    if (timeout_hit) begin
      state_d   = ST_HUNT;
      err_fire  = 1'b1;
      err_cause = ERR_TIMEOUT;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (accept && (bus.in_data == SYNC)) state_d = ST_LEN;
        end
        ST_LEN: begin
          if (accept) begin
            if (len_ok) begin
              state_d = ST_PAYLOAD;
            end else begin
              // The rejected length byte is consumed, never re-hunted as SYNC.
              state_d   = ST_HUNT;
              err_fire  = 1'b1;
              err_cause = ERR_BAD_LEN;
            end
          end
        end
        ST_PAYLOAD: begin
          if (accept && (8'(wr_ptr_q) == last_idx)) state_d = ST_CHK;
        end
        ST_CHK: begin
          if (accept) begin
            if (bus.in_data == sum_q) begin
              state_d = ST_DRAIN;
            end else begin
              state_d   = ST_HUNT;
              err_fire  = 1'b1;
              err_cause = ERR_BAD_CHK;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && bus.out_last) state_d = ST_HUNT;
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // Frame bookkeeping: length, running checksum, pointers, idle counter, error strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q       <= '0;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      idle_q      <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      err_valid_q <= err_fire;
      if (err_fire) err_code_q <= err_cause;

      // Idle time only matters inside a frame; every accepted byte restarts it.
      if (accept || !next_in_frame) begin
        idle_q <= '0;
      end else if (idle_q != IDLE_SAT) begin
        idle_q <= idle_q + IDLE_W'(1);
      end

      case (state_q)
        ST_LEN: begin
          if (accept && len_ok) begin
            len_q    <= bus.in_data;
            sum_q    <= bus.in_data;
            wr_ptr_q <= '0;
          end
        end
        ST_PAYLOAD: begin
          if (accept) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            sum_q    <= sum_q + bus.in_data;
          end
        end
        ST_CHK: begin
          if (accept) rd_ptr_q <= '0;
        end
        ST_DRAIN: begin
          if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Payload buffer write port.
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset; a slot is always written for the current
    // frame before it is read, so stale contents are never visible.
    if ((state_q == ST_PAYLOAD) && accept) begin
      payload_mem[wr_ptr_q[ADDR_W-1:0]] <= bus.in_data;
    end
  end

endmodule
